char_row_renderer: RTL
======================

Name: char_row_renderer

Overview:
- Parametrised successor to the inline character renderer in the SVGA text top level.
- Renders one pixel row of one text row into the pixel buffer:
  - fetches code/attribute words from the character row buffer;
  - looks up glyph patterns in font memory and fg/bg colours in the palette;
  - writes one pixel per clock to the pixel buffer.
- Generalised in column count, glyph size, colour width and buffer depth; adds a start/busy/done handshake, optional double-buffered (banked) pixel buffer output and a cursor overlay.

Parameters:
- COLS, 100, characters per text row
- GLYPH_W, 8, pixels per glyph row (5..8); pattern MSB is the leftmost pixel
- GLYPH_H_LOG2, 4, log2 glyph height; row index width
- PIX_W, 16, colour word width (palette data = pixbuf data)
- CHROW_AW, 8, chrowbuf address width
- PAL_AW, 8, palette address width
- PIXBUF_AW, 10, pixbuf address width
- DOUBLE_BUF, 0, 1 = pixbuf address MSB selects bank

Ports:
- clk  in  1  pixel clock, 40 MHz
- nrst  in  1  reset, active-low
- start  in  1  begin one row render (single-cycle pulse)
- pixel_row  in  GLYPH_H_LOG2  glyph row to render, sampled with start
- bank  in  1  target pixbuf bank, sampled with start; ignored if DOUBLE_BUF=0
- cursor_en  in  1  cursor enabled on this text row, sampled with start
- cursor_col  in  CHROW_AW  cursor column, sampled with start
- cursor_on  in  1  blink phase, sampled with start
- busy  out  1  render in progress
- done  out  1  one-cycle pulse after the last pixel write
- chrowbuf_rd  out  1  read enable, active-low
- chrowbuf_rd_addr  out  CHROW_AW  column index
- chrowbuf_rd_data  in  16  [15:12] bg index, [11:8] fg index, [7:0] char code
- fontmem_rd  out  1  read enable, active-low
- fontmem_rd_addr  out  8+GLYPH_H_LOG2  {char code, pixel_row}
- fontmem_rd_data  in  8  glyph pattern
- palette_rd  out  1  read enable, active-low
- palette_rd_addr  out  PAL_AW  colour index, zero-extended
- palette_rd_data  in  PIX_W  colour
- pixbuf_wr  out  1  write enable, active-low
- pixbuf_wr_addr  out  PIXBUF_AW  pixel address
- pixbuf_wr_data  out  PIX_W  pixel colour

Behaviour:
- Clock, reset and enables:
  - Single clock clk; reset nrst asynchronous, active-low.
  - All memories have 1-cycle read latency. All enables are active-low and deassert (1) when not in use.
- Reset values:
  - busy=0, done=0.
  - chrowbuf_rd=1, fontmem_rd=1, palette_rd=1, pixbuf_wr=1.
  - All addresses 0, pixbuf_wr_data=0, FSM=IDLE.
- FSM states:
  - IDLE: start=1 latches the sampled inputs, sets busy=1 next cycle, enters PRIME. start is ignored in any other state.
  - PRIME (4 cycles):
    - p0: chrowbuf read, column 0.
    - p1: fontmem read {code, pixel_row}; palette read fg index.
    - p2: latch pattern and fg; palette read bg index.
    - p3: latch bg into next-cell registers, then enter EMIT.
  - EMIT (COLS*GLYPH_W cycles):
    - Slot counter k = 0..GLYPH_W-1 per cell.
    - At k=0 the next-cell registers move to the current-cell registers.
    - Each cycle: pixbuf_wr=0, data = pattern MSB ? fg : bg, then shift the pattern left.
    - During k=0..3 of cell c, the PRIME fetch sequence runs for column c+1; it is suppressed for the last cell.
  - DONE (1 cycle): pixbuf_wr=1, done=1, busy=0 on the following cycle, return to IDLE.
- Timing:
  - If start is sampled high at edge 0, the first pixbuf_wr=0 appears after edge 5.
  - busy stays high for exactly 5+COLS*GLYPH_W cycles.
- Address arithmetic:
  - x runs 0..COLS*GLYPH_W-1.
  - pixbuf_wr_addr = x when DOUBLE_BUF=0.
  - pixbuf_wr_addr = {bank, x[PIXBUF_AW-2:0]} when DOUBLE_BUF=1.
  - Elaboration error if COLS*GLYPH_W exceeds the bank size, or if GLYPH_W<5 or GLYPH_W>8.
- Cursor: when cursor_en & cursor_on and column == cursor_col, that cell's fg and bg are swapped. cursor_col >= COLS has no effect.
- Glyph width: with GLYPH_W<8, only pattern bits [7:8-GLYPH_W] are emitted.
- Reset mid-render: all outputs return to reset values immediately; no further writes; no done pulse.
- Palette address: fg and bg indices are 4 bits each, zero-extended to PAL_AW.

Decomposition:
- Shared package (e.g. icevga_pkg):
  - attribute field positions (BG_MSB/LSB, FG_MSB/LSB, CODE_MSB/LSB);
  - active-low enable constants (EN=1'b0, DIS=1'b1);
  - FSM state encoding.
- One natural sub-module: glyph_shifter, holding the current/next pattern, fg and bg registers, the left shift and the colour mux.

Test Plan:
- Reset, then a start pulse with COLS=100, pixel_row=3:
  - busy high 805 cycles;
  - 800 writes to addresses 0..799;
  - a single done pulse;
  - fontmem addresses {code,3}.
- Column 0 word 16'h21AA, palette[1]=16'h0CC0, palette[2]=16'h0004, font pattern 8'b10001010:
  - pixels 0..7 = CC0,004,004,004,CC0,004,CC0,004.
- DOUBLE_BUF=1, PIXBUF_AW=11, bank=1:
  - first write address 1024, last 1823;
  - no writes below 1024.
- cursor_en=1, cursor_on=1, cursor_col=5: pixels 40..47 show swapped colours.
  - Same with cursor_on=0: normal colours.
- nrst low at EMIT cycle 300:
  - pixbuf_wr=1 and busy=0 without a clock edge;
  - no done;
  - the next start renders the full row normally.
- start pulsed again while busy: ignored, exactly 800 writes, one done.

Source files
------------

// File: rtl/char_row_renderer_pkg.sv
// Shared definitions for the character row renderer.
//   - attribute word field positions in a character row buffer entry
//   - active-low enable levels used on every memory strobe
//   - FSM state encoding
package char_row_renderer_pkg;

  // Character row buffer word: [15:12] bg index, [11:8] fg index, [7:0] code
  localparam int BG_MSB   = 15;
  localparam int BG_LSB   = 12;
  localparam int FG_MSB   = 11;
  localparam int FG_LSB   = 8;
  localparam int CODE_MSB = 7;
  localparam int CODE_LSB = 0;

  // Memory strobes are active-low
  localparam logic EN  = 1'b0;
  localparam logic DIS = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/char_row_renderer_if.sv
// Memory-side bus bundle of the character row renderer.
//   chrowbuf_*  : read port of the character row buffer (code/attribute words)
//   fontmem_*   : read port of the font memory (glyph patterns)
//   palette_*   : read port of the colour palette
//   pixbuf_*    : write port of the pixel buffer
// master = renderer side, slave = memory side. All strobes active-low.
interface char_row_renderer_if #(
  parameter int CHROW_AW     = 8,
  parameter int GLYPH_H_LOG2 = 4,
  parameter int PIX_W        = 16,
  parameter int PAL_AW       = 8,
  parameter int PIXBUF_AW    = 10
);
  logic                      chrowbuf_rd;
  logic [CHROW_AW-1:0]       chrowbuf_rd_addr;
  logic [15:0]               chrowbuf_rd_data;
  logic                      fontmem_rd;
  logic [8+GLYPH_H_LOG2-1:0] fontmem_rd_addr;
  logic [7:0]                fontmem_rd_data;
  logic                      palette_rd;
  logic [PAL_AW-1:0]         palette_rd_addr;
  logic [PIX_W-1:0]          palette_rd_data;
  logic                      pixbuf_wr;
  logic [PIXBUF_AW-1:0]      pixbuf_wr_addr;
  logic [PIX_W-1:0]          pixbuf_wr_data;

  modport master (
    output chrowbuf_rd, chrowbuf_rd_addr, input chrowbuf_rd_data,
    output fontmem_rd, fontmem_rd_addr, input fontmem_rd_data,
    output palette_rd, palette_rd_addr, input palette_rd_data,
    output pixbuf_wr, pixbuf_wr_addr, pixbuf_wr_data
  );

  modport slave (
    input chrowbuf_rd, chrowbuf_rd_addr, output chrowbuf_rd_data,
    input fontmem_rd, fontmem_rd_addr, output fontmem_rd_data,
    input palette_rd, palette_rd_addr, output palette_rd_data,
    input pixbuf_wr, pixbuf_wr_addr, pixbuf_wr_data
  );
endinterface

// File: rtl/char_row_renderer_glyph_shifter.sv
// Glyph pixel generator: holds the "next cell" pattern/fg/bg (filled while the
// current cell is being emitted) and the "current cell" registers, shifts the
// pattern left one pixel per emit cycle and selects fg or bg from its MSB.
//   clk, nrst  : clock, asynchronous active-low reset
//   ld_fg      : capture font pattern and fg colour into next-cell registers
//   ld_bg      : capture bg colour into next-cell register
//   font_data  : glyph pattern from font memory
//   pal_data   : colour word from palette
//   emit       : produce one pixel this cycle
//   emit_load  : first slot of a cell; take next-cell registers as source
//   pix_data   : registered pixel colour
module char_row_renderer_glyph_shifter #(
  parameter int PIX_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ld_fg,
  input  logic             ld_bg,
  input  logic [7:0]       font_data,
  input  logic [PIX_W-1:0] pal_data,
  input  logic             emit,
  input  logic             emit_load,
  output logic [PIX_W-1:0] pix_data
);
  logic [7:0]       nxt_pat_reg, cur_pat_reg;
  logic [PIX_W-1:0] nxt_fg_reg, nxt_bg_reg, cur_fg_reg, cur_bg_reg, pix_reg;

  // On the first slot of a cell the next-cell registers feed the mux
  // directly, so the cell's first pixel leaves in the same cycle as the load.
  logic [7:0]       src_pat;
  logic [PIX_W-1:0] src_fg, src_bg;
  assign src_pat = emit_load ? nxt_pat_reg : cur_pat_reg;
  assign src_fg  = emit_load ? nxt_fg_reg  : cur_fg_reg;
  assign src_bg  = emit_load ? nxt_bg_reg  : cur_bg_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nxt_pat_reg <= '0;
      nxt_fg_reg  <= '0;
      nxt_bg_reg  <= '0;
      cur_pat_reg <= '0;
      cur_fg_reg  <= '0;
      cur_bg_reg  <= '0;
      pix_reg     <= '0;
    end else begin
      if (ld_fg) begin
        nxt_pat_reg <= font_data;
        nxt_fg_reg  <= pal_data;
      end
      if (ld_bg) nxt_bg_reg <= pal_data;
      if (emit) begin
        cur_pat_reg <= {src_pat[6:0], 1'b0};
        cur_fg_reg  <= src_fg;
        cur_bg_reg  <= src_bg;
        pix_reg     <= src_pat[7] ? src_fg : src_bg;
      end
    end
  end

  assign pix_data = pix_reg;
endmodule

// File: rtl/char_row_renderer.sv
// Renders one pixel row of one text row into the pixel buffer.
//   clk, nrst           : pixel clock, asynchronous active-low reset
//   start               : one-cycle pulse, samples pixel_row/bank/cursor_*
//   pixel_row, bank     : glyph row to draw, target pixbuf bank
//   cursor_en/col/on    : cursor overlay (fg/bg swapped on the cursor cell)
//   busy, done          : render in progress / one-cycle completion pulse
//   bus                 : memory ports (chrowbuf, fontmem, palette, pixbuf)
// A 4-cycle PRIME phase fetches cell 0; during EMIT the same 4-step fetch for
// cell c+1 overlaps slots 0..3 of cell c, giving one pixel write per clock.
module char_row_renderer
  import char_row_renderer_pkg::*;
#(
  parameter int COLS         = 100,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H_LOG2 = 4,
  parameter int PIX_W        = 16,
  parameter int CHROW_AW     = 8,
  parameter int PAL_AW       = 8,
  parameter int PIXBUF_AW    = 10,
  parameter int DOUBLE_BUF   = 0
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic [GLYPH_H_LOG2-1:0] pixel_row,
  input  logic                    bank,
  input  logic                    cursor_en,
  input  logic [CHROW_AW-1:0]     cursor_col,
  input  logic                    cursor_on,
  output logic                    busy,
  output logic                    done,
  char_row_renderer_if.master     bus
);
  localparam int BANK_SIZE = (DOUBLE_BUF != 0) ? 2 ** (PIXBUF_AW - 1) : 2 ** PIXBUF_AW;
  localparam logic [2:0]          LAST_K   = 3'(GLYPH_W - 1);
  localparam logic [CHROW_AW-1:0] LAST_COL = CHROW_AW'(COLS - 1);

  if (GLYPH_W < 5 || GLYPH_W > 8) begin : g_bad_glyph_w
    $error("char_row_renderer: GLYPH_W must be in 5..8");
  end
  if (COLS * GLYPH_W > BANK_SIZE) begin : g_bad_bank_size
    $error("char_row_renderer: COLS*GLYPH_W exceeds pixbuf bank size");
  end
  if (COLS > 2 ** CHROW_AW || PAL_AW < 4) begin : g_bad_widths
    $error("char_row_renderer: CHROW_AW or PAL_AW too narrow");
  end

  state_t                  state_reg, state_next;
  logic [2:0]              k_reg, k_next;        // PRIME step or EMIT slot
  logic [CHROW_AW-1:0]     col_reg, col_next;    // cell being emitted
  logic [PIXBUF_AW-1:0]    x_reg, x_next;        // pixel index in the row
  logic [GLYPH_H_LOG2-1:0] row_reg, row_next;
  logic                    bank_reg, bank_next;
  logic                    cur_vis_reg, cur_vis_next;
  logic [CHROW_AW-1:0]     ccol_reg, ccol_next;
  logic [3:0]              idx2_reg, idx2_next;  // second palette index
  logic                    busy_reg, busy_next, done_reg, done_next;
  logic                    wr_reg, wr_next;
  logic [PIXBUF_AW-1:0]    waddr_reg, waddr_next;

  // Fetch sequencing shared by PRIME and the overlapped fetch in EMIT
  logic                fetch_act, in_prime, last_col, last_k, cursor_hit;
  logic [1:0]          ph;
  logic [CHROW_AW-1:0] fetch_col;
  logic [7:0]          code;
  logic [3:0]          fg_idx, bg_idx, first_idx, second_idx;

  assign in_prime   = (state_reg == S_PRIME);
  assign last_col   = (col_reg == LAST_COL);
  assign last_k     = (k_reg == LAST_K);
  assign fetch_act  = in_prime || (state_reg == S_EMIT && !last_col && !k_reg[2]);
  assign ph         = k_reg[1:0];
  assign fetch_col  = in_prime ? '0 : col_reg + CHROW_AW'(1);
  assign cursor_hit = cur_vis_reg && (fetch_col == ccol_reg);
  assign code       = bus.chrowbuf_rd_data[CODE_MSB:CODE_LSB];
  assign fg_idx     = bus.chrowbuf_rd_data[FG_MSB:FG_LSB];
  assign bg_idx     = bus.chrowbuf_rd_data[BG_MSB:BG_LSB];
  // Cursor swap is done on the palette indices, so the colours land swapped.
  assign first_idx  = cursor_hit ? bg_idx : fg_idx;
  assign second_idx = cursor_hit ? fg_idx : bg_idx;

  // Read strobes/addresses decode straight from the fetch step; the font and
  // first palette addresses come from the word the row buffer returns now.
  assign bus.chrowbuf_rd      = (fetch_act && ph == 2'd0) ? EN : DIS;
  assign bus.chrowbuf_rd_addr = (fetch_act && ph == 2'd0) ? fetch_col : '0;
  assign bus.fontmem_rd       = (fetch_act && ph == 2'd1) ? EN : DIS;
  assign bus.fontmem_rd_addr  = (fetch_act && ph == 2'd1) ? {code, row_reg} : '0;
  assign bus.palette_rd       = (fetch_act && (ph == 2'd1 || ph == 2'd2)) ? EN : DIS;
  assign bus.palette_rd_addr  = !fetch_act  ? '0 :
                                (ph == 2'd1) ? PAL_AW'(first_idx) :
                                (ph == 2'd2) ? PAL_AW'(idx2_reg) : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= S_IDLE;
      k_reg       <= '0;
      col_reg     <= '0;
      x_reg       <= '0;
      row_reg     <= '0;
      bank_reg    <= 1'b0;
      cur_vis_reg <= 1'b0;
      ccol_reg    <= '0;
      idx2_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      wr_reg      <= DIS;
      waddr_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      k_reg       <= k_next;
      col_reg     <= col_next;
      x_reg       <= x_next;
      row_reg     <= row_next;
      bank_reg    <= bank_next;
      cur_vis_reg <= cur_vis_next;
      ccol_reg    <= ccol_next;
      idx2_reg    <= idx2_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      wr_reg      <= wr_next;
      waddr_reg   <= waddr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    col_next     = col_reg;
    x_next       = x_reg;
    row_next     = row_reg;
    bank_next    = bank_reg;
    cur_vis_next = cur_vis_reg;
    ccol_next    = ccol_reg;
    idx2_next    = idx2_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    wr_next      = DIS;
    waddr_next   = waddr_reg;

    if (fetch_act && ph == 2'd1) idx2_next = second_idx;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          row_next     = pixel_row;
          bank_next    = bank;
          cur_vis_next = cursor_en & cursor_on;
          ccol_next    = cursor_col;
          k_next       = '0;
          col_next     = '0;
          x_next       = '0;
          busy_next    = 1'b1;
          state_next   = S_PRIME;
        end
      end
      S_PRIME: begin
        k_next = k_reg + 3'd1;
        if (k_reg == 3'd3) begin
          k_next     = '0;
          state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        wr_next    = EN;
        waddr_next = (DOUBLE_BUF != 0) ? {bank_reg, x_reg[PIXBUF_AW-2:0]} : x_reg;
        x_next     = x_reg + PIXBUF_AW'(1);
        k_next     = k_reg + 3'd1;
        if (last_k) begin
          k_next = '0;
          if (last_col) state_next = S_DONE;
          else          col_next   = col_reg + CHROW_AW'(1);
        end
      end
      S_DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  char_row_renderer_glyph_shifter #(.PIX_W(PIX_W)) u_shifter (
    .clk       (clk),
    .nrst      (nrst),
    .ld_fg     (fetch_act && ph == 2'd2),
    .ld_bg     (fetch_act && ph == 2'd3),
    .font_data (bus.fontmem_rd_data),
    .pal_data  (bus.palette_rd_data),
    .emit      (state_reg == S_EMIT),
    .emit_load (k_reg == 3'd0),
    .pix_data  (bus.pixbuf_wr_data)
  );

  assign bus.pixbuf_wr      = wr_reg;
  assign bus.pixbuf_wr_addr = waddr_reg;
  assign busy               = busy_reg;
  assign done               = done_reg;
endmodule
